// File: rtl/c499_lock_pkg.sv
// Shared types and constants for the c499 key loader.
// The C499_KEY_CRC_EN build option adds the CRC-8 check.
package c499_lock_pkg;

  localparam int C499_KEY_W = 32;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_KEY,
    SHIFT_CRC,
    ARMED,
    ERROR
  } key_ld_state_t;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (non-reflected), one input bit per enabled cycle.
// Used by c499_key_loader when C499_KEY_CRC_EN is defined.
module crc8_serial
  import c499_lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ din_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC8_INIT;
    end else if (en_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC8_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/c499_key_loader.sv
// Serial key loader driving keyIn_0_* of the locked c499 core.
// Define C499_KEY_CRC_EN to append and verify a CRC-8 after the key.
module c499_key_loader
  import c499_lock_pkg::*;
#(
  parameter int KEY_W   = C499_KEY_W,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_armed,
  output logic             key_err,
  output logic             busy
);

  localparam int CW = $clog2(KEY_W);
  localparam int IW = $clog2(TIMEOUT + 1);

  key_ld_state_t    state_q, state_d;
  logic [KEY_W-1:0] sr_q, sr_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             armed_q, err_q, busy_q;
  logic             beat;

`ifdef C499_KEY_CRC_EN
  logic [7:0] rx_q, rx_d;
  logic [7:0] crc;
  logic       crc_clr, crc_en;

  crc8_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .din_i (ser_data),
    .crc_o (crc)
  );
`endif

  assign beat = ser_valid & busy_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
`ifdef C499_KEY_CRC_EN
    rx_d    = rx_q;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
`endif
    unique case (state_q)
      IDLE, ARMED, ERROR: begin
        if (load_start) begin
          state_d = SHIFT_KEY;
          sr_d    = '0;
          key_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
`ifdef C499_KEY_CRC_EN
          rx_d    = '0;
          crc_clr = 1'b1;
`endif
        end
      end
      SHIFT_KEY: begin
        if (beat) begin
          sr_d   = {ser_data, sr_q[KEY_W-1:1]};
          cnt_d  = cnt_q + CW'(1);
          idle_d = '0;
`ifdef C499_KEY_CRC_EN
          crc_en = 1'b1;
          if (cnt_q == CW'(KEY_W - 1)) begin
            state_d = SHIFT_CRC;
            cnt_d   = '0;
          end
`else
          if (cnt_q == CW'(KEY_W - 1)) begin
            key_d   = sr_d;
            state_d = ARMED;
          end
`endif
        end
      end
`ifdef C499_KEY_CRC_EN
      SHIFT_CRC: begin
        if (beat) begin
          rx_d   = {rx_q[6:0], ser_data};
          cnt_d  = cnt_q + CW'(1);
          idle_d = '0;
          if (cnt_q == CW'(7)) begin
            if (rx_d == crc) begin
              key_d   = sr_q;
              state_d = ARMED;
            end else begin
              state_d = ERROR;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Timeout only on idle cycles, so a beat on the deadline cycle wins.
    if (busy_q && !beat) begin
      idle_d = idle_q + IW'(1);
      if (idle_d == IW'(TIMEOUT)) state_d = ERROR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      armed_q <= (state_d == ARMED);
      err_q   <= (state_d == ERROR);
      busy_q  <= (state_d == SHIFT_KEY) || (state_d == SHIFT_CRC);
    end
  end

`ifdef C499_KEY_CRC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_q <= '0;
    else     rx_q <= rx_d;
  end
`endif

  assign key_out   = key_q;
  assign key_armed = armed_q;
  assign key_err   = err_q;
  assign busy      = busy_q;
  assign ser_ready = busy_q;

endmodule
